// File: rtl/memory_access_unit_if.sv
// Avalon-MM data-bus signals between the memory-stage load/store unit
// and the data memory.
interface memory_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: turns the memory-stage opcode and address into
// one Avalon-MM transfer and registers raw results into the writeback stage.
module memory_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_memory,
    input  logic [5:0]            op_memory,
    input  logic [31:0]           alu_out_memory,
    input  logic [31:0]           src_A_memory,
    input  logic [31:0]           src_B_memory,
    output logic                  stall_memory,
    memory_access_unit_if.master  bus,
    output logic                  valid_writeback,
    output logic [5:0]            op_writeback,
    output logic [3:0]            byteenable_writeback,
    output logic [31:0]           src_A_writeback,
    output logic [31:0]           src_B_writeback,
    output logic [31:0]           read_data_writeback,
    output logic                  addr_error_writeback
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_e;

    state_e            state_q;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] address_q;
    logic [3:0]        byteenable_q;
    logic [31:0]       writedata_q;

    logic [1:0]        lane;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic              access_req;
    logic [3:0]        byteenable_d;
    logic [31:0]       writedata_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        lane         = alu_out_memory[1:0];
        is_load      = 1'b0;
        is_store     = 1'b0;
        misaligned   = 1'b0;
        byteenable_d = 4'b0000;
        writedata_d  = 32'd0;
        case (op_memory)
            OP_LB, OP_LBU: begin
                is_load      = 1'b1;
                byteenable_d = 4'b0001 << lane;
            end
            OP_LH, OP_LHU: begin
                is_load      = 1'b1;
                byteenable_d = lane[1] ? 4'b1100 : 4'b0011;
                misaligned   = lane[0];
            end
            OP_LW: begin
                is_load      = 1'b1;
                byteenable_d = 4'b1111;
                misaligned   = (lane != 2'b00);
            end
            OP_LWL: begin
                is_load      = 1'b1;
                byteenable_d = 4'b1111 >> (2'd3 - lane);
            end
            OP_LWR: begin
                is_load      = 1'b1;
                byteenable_d = 4'b1111 << lane;
            end
            OP_SB: begin
                is_store     = 1'b1;
                byteenable_d = 4'b0001 << lane;
                writedata_d  = {24'd0, src_B_memory[7:0]} << {lane, 3'b000};
            end
            OP_SH: begin
                is_store     = 1'b1;
                byteenable_d = lane[1] ? 4'b1100 : 4'b0011;
                writedata_d  = lane[1] ? {src_B_memory[15:0], 16'd0} : {16'd0, src_B_memory[15:0]};
                misaligned   = lane[0];
            end
            OP_SW: begin
                is_store     = 1'b1;
                byteenable_d = 4'b1111;
                writedata_d  = src_B_memory;
                misaligned   = (lane != 2'b00);
            end
            default: ;
        endcase

        access_req   = valid_memory & (is_load | is_store) & ~misaligned;
        // Outside IDLE the held instruction is released in the cycle the slave accepts.
        stall_memory = (state_q == IDLE) ? access_req : bus.waitrequest;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            byteenable_q <= 4'b0000;
            writedata_q  <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        address_q    <= {alu_out_memory[ADDR_W-1:2], 2'b00};
                        byteenable_q <= byteenable_d;
                        writedata_q  <= writedata_d;
                        read_q       <= is_load;
                        write_q      <= is_store;
                        state_q      <= is_load ? READ_WAIT : WRITE_WAIT;
                    end
                end
                READ_WAIT, WRITE_WAIT: begin
                    if (!bus.waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_writeback      <= 1'b0;
            op_writeback         <= 6'd0;
            byteenable_writeback <= 4'b0000;
            src_A_writeback      <= 32'd0;
            src_B_writeback      <= 32'd0;
            read_data_writeback  <= 32'd0;
            addr_error_writeback <= 1'b0;
        end else if (!stall_memory) begin
            valid_writeback      <= valid_memory;
            op_writeback         <= op_memory;
            src_A_writeback      <= src_A_memory;
            src_B_writeback      <= src_B_memory;
            addr_error_writeback <= valid_memory & (is_load | is_store) & misaligned;
            byteenable_writeback <= (state_q == IDLE) ? 4'b0000 : byteenable_q;
            read_data_writeback  <= (state_q == READ_WAIT) ? bus.readdata : 32'd0;
        end else begin
            valid_writeback <= 1'b0;
        end
    end

    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.byteenable = byteenable_q;
    assign bus.writedata  = writedata_q;

endmodule
